// File: rtl/cla_adder_if.sv
// Operand/result bundle for cla_adder: the operand side drives a/b/cin/in_valid,
// the adder returns the registered sum and flags.
interface cla_adder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             pg;
    logic             gg;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  s, cout, ovf, pg, gg, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output s, cout, ovf, pg, gg, out_valid
    );
endinterface

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder built from 4-bit groups.
// One-cycle latency; all results load every cycle, out_valid only qualifies them.
module cla_adder #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    cla_adder_if.slave bus
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NG-1:0]    w_grp_p;
    logic [NG-1:0]    w_grp_g;
    logic [NG:0]      w_grp_c;
    logic [WIDTH:0]   w_c;
    logic             w_blk_g;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_pg;
    logic             r_gg;
    logic             r_out_valid;

    // Group generate/propagate as flat sum-of-products: {G, P}.
    function automatic logic [1:0] grp_pg(input logic [3:0] p, input logic [3:0] g);
        logic v_g;
        logic v_p;
        v_p = p[3] & p[2] & p[1] & p[0];
        v_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {v_g, v_p};
    endfunction

    // Internal carries c3..c1 of one group, each a direct lookahead term.
    function automatic logic [2:0] grp_carry(input logic [3:0] p, input logic [3:0] g,
                                             input logic c0);
        logic v_c1;
        logic v_c2;
        logic v_c3;
        v_c1 = g[0] | (p[0] & c0);
        v_c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        v_c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return {v_c3, v_c2, v_c1};
    endfunction

    assign w_p = bus.a ^ bus.b;
    assign w_g = bus.a & bus.b;

    always_comb begin
        logic v_acc;
        logic v_term;
        logic v_all_p;
        w_grp_p = '0;
        w_grp_g = '0;
        w_grp_c = '0;
        w_c     = '0;
        w_blk_g = 1'b0;
        v_acc   = 1'b0;
        v_term  = 1'b0;
        v_all_p = 1'b0;

        for (int k = 0; k < NG; k++) begin
            {w_grp_g[k], w_grp_p[k]} = grp_pg(w_p[4*k +: 4], w_g[4*k +: 4]);
        end

        // Second level: each group carry-in is an OR of products of group P/G terms,
        // independent of the neighbouring group's carry output.
        w_grp_c[0] = bus.cin;
        for (int j = 1; j <= NG; j++) begin
            v_acc = 1'b0;
            for (int k = 0; k < j; k++) begin
                v_term = w_grp_g[k];
                for (int m = k + 1; m < j; m++) begin
                    v_term = v_term & w_grp_p[m];
                end
                v_acc = v_acc | v_term;
            end
            if (j == NG) begin
                w_blk_g = v_acc;
            end
            v_all_p = 1'b1;
            for (int m = 0; m < j; m++) begin
                v_all_p = v_all_p & w_grp_p[m];
            end
            w_grp_c[j] = v_acc | (v_all_p & bus.cin);
        end

        for (int k = 0; k < NG; k++) begin
            w_c[4*k] = w_grp_c[k];
            w_c[4*k+1 +: 3] = grp_carry(w_p[4*k +: 4], w_g[4*k +: 4], w_grp_c[k]);
        end
        w_c[WIDTH] = w_grp_c[NG];
    end

    assign w_sum = w_p ^ w_c[WIDTH-1:0];
    assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_pg        <= 1'b0;
            r_gg        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_s         <= w_sum;
            r_cout      <= w_c[WIDTH];
            r_ovf       <= w_ovf;
            r_pg        <= &w_grp_p;
            r_gg        <= w_blk_g;
            r_out_valid <= bus.in_valid;
        end
    end

    assign bus.s         = r_s;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.pg        = r_pg;
    assign bus.gg        = r_gg;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder (WIDTH=4): directed cases, reset behaviour,
// exhaustive sweep and random traffic against an arithmetic reference model.
module tb_cla_adder;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cla_adder_if #(.WIDTH(W)) bus ();

    cla_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic vld);
        int total;
        int sa;
        int sb;
        int ssum;
        int total0;
        total  = int'(a) + int'(b) + int'(cin);
        total0 = int'(a) + int'(b);
        sa     = int'(a) - (a[W-1] ? (1 << W) : 0);
        sb     = int'(b) - (b[W-1] ? (1 << W) : 0);
        ssum   = sa + sb + int'(cin);
        check({tag, ".s"},    8'(bus.s),     8'(total % (1 << W)));
        check({tag, ".cout"}, 8'(bus.cout),  8'(total >= (1 << W)));
        check({tag, ".ovf"},  8'(bus.ovf),   8'((ssum > (1 << (W-1)) - 1) || (ssum < -(1 << (W-1)))));
        check({tag, ".pg"},   8'(bus.pg),    8'((a ^ b) == {W{1'b1}}));
        check({tag, ".gg"},   8'(bus.gg),    8'(total0 >= (1 << W)));
        check({tag, ".vld"},  8'(bus.out_valid), 8'(vld));
    endtask

    task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic vld);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = vld;
        @(posedge clk);
        #1;
        check_result(tag, a, b, cin, vld);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".s"},    8'(bus.s),    8'h00);
        check({tag, ".cout"}, 8'(bus.cout), 8'h00);
        check({tag, ".ovf"},  8'(bus.ovf),  8'h00);
        check({tag, ".pg"},   8'(bus.pg),   8'h00);
        check({tag, ".gg"},   8'(bus.gg),   8'h00);
        check({tag, ".vld"},  8'(bus.out_valid), 8'h00);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 4'b0111;
        bus.b        = 4'b0111;
        bus.cin      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        step("d1_1p2p1",   4'b0001, 4'b0010, 1'b1, 1'b1);
        check("d1_s_const", 8'(bus.s), 8'h04);
        step("d2_3p5",     4'b0011, 4'b0101, 1'b0, 1'b1);
        check("d2_ovf_const", 8'(bus.ovf), 8'h01);
        step("d3_prop",    4'b1010, 4'b0101, 1'b0, 1'b1);
        check("d3_pg_const", 8'(bus.pg), 8'h01);
        step("d4_10p12p1", 4'b1010, 4'b1100, 1'b1, 1'b1);
        check("d4_s_const", 8'(bus.s), 8'h07);
        step("d5_wrap",    4'b1111, 4'b0001, 1'b0, 1'b1);
        step("d6_ff",      4'b1111, 4'b1111, 1'b0, 1'b1);
        check("d6_gg_const", 8'(bus.gg), 8'h01);
        step("d7_novalid", 4'b0110, 4'b0011, 1'b1, 1'b0);

        // Mid-cycle asynchronous reset after a valid add
        step("r_pre",      4'b1001, 4'b1000, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("r_async");
        @(posedge clk);
        #1;
        check_zero("r_held");
        @(negedge clk);
        rst = 1'b0;
        step("r_post",     4'b0101, 4'b0011, 1'b0, 1'b1);
        check("r_post_s_const", 8'(bus.s), 8'h08);
        check("r_post_vld_const", 8'(bus.out_valid), 8'h01);

        // Exhaustive sweep
        for (int i = 0; i < 512; i++) begin
            step("sweep", 4'(i >> 5), 4'(i >> 1), 1'(i), 1'b1);
        end

        // Random traffic with random in_valid
        for (int i = 0; i < 200; i++) begin
            step("rand", 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
